smem_writer: RTL and testbench

//  Write-side counterpart of the VGA character display: the driver only reads screen memory,

---
 rtl/smem_pkg.sv | 45 ++++
 rtl/smem_cmd_fifo.sv | 79 +++++++
 rtl/smem_writer.sv | 245 ++++++++++++++++++++++++
 tb/tb_smem_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// ----------------------------------------------------------------------------
// smem_pkg
//   Shared types and default geometry for the screen-memory writer.
//   - op_t    : command opcodes (WRITE one cell, FILL whole screen, two reserved)
//   - state_t : writer FSM states
//   - cmd_t   : one buffered command as it sits in the command FIFO
//   The cmd_t field widths follow the default geometry below; a writer built
//   with a larger nrows/ncols/Nchars needs these defaults raised to match.
// ----------------------------------------------------------------------------
package smem_pkg;

    localparam int NCHARS    = 4;
    localparam int NROWS     = 30;
    localparam int NCOLS     = 40;
    localparam int SMEM_SIZE = NROWS * NCOLS;

    localparam int ROW_W  = $clog2(NROWS);
    localparam int COL_W  = $clog2(NCOLS);
    localparam int CHAR_W = $clog2(NCHARS);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_FILL  = 2'b01,
        OP_RSV2  = 2'b10,
        OP_RSV3  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_GATE,
        ST_WRITE,
        ST_FILL
    } state_t;

    typedef struct packed {
        op_t               op;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [CHAR_W-1:0] chr;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/smem_cmd_fifo.sv
// ----------------------------------------------------------------------------
// smem_cmd_fifo
//   Synchronous FIFO for writer commands with a registered read port: a pop
//   loads the head entry into pop_data, which then holds until the next pop.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset (pointers only)
//     push, push_data   write request; ignored while full
//     pop               read request; ignored while empty
//     pop_data          entry taken by the most recent accepted pop
//     full, empty       occupancy flags (from registered pointers only)
// ----------------------------------------------------------------------------
module smem_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Flags come from registered pointers, so a same-cycle pop never makes
    // room for a push while full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_data_d = pop_data_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
            pop_data_d = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
    end

    // Storage array carries no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign pop_data = pop_data_q;

endmodule

// File: rtl/smem_writer.sv
// ----------------------------------------------------------------------------
// smem_writer
//   Write side of the character display's screen memory. Accepts WRITE (one
//   cell) and FILL (whole screen) commands over valid/ready, buffers them in
//   a small FIFO and drives the write port of the dual-port screen RAM.
//   Writes may be restricted to vertical blanking so the display never shows
//   a half-updated frame.
//   Ports:
//     clk, reset_n             clock, asynchronous active-low reset
//     cmd_valid / cmd_ready    command handshake (ready = FIFO not full)
//     cmd_op/row/col/char      command payload
//     vsync                    active-low vsync from the display (async)
//     wr_en/wr_addr/wr_data    registered screen RAM write port
//     busy                     FIFO non-empty or FSM not idle
//     done                     1-cycle pulse after the last write of a command
//     err                      1-cycle pulse when a command is dropped
// ----------------------------------------------------------------------------
module smem_writer
    import smem_pkg::*;
#(
    parameter int Nchars         = NCHARS,
    parameter int smem_size      = SMEM_SIZE,
    parameter int ncols          = NCOLS,
    parameter int nrows          = NROWS,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_TO_VBLANK = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(nrows)-1:0]     cmd_row,
    input  logic [$clog2(ncols)-1:0]     cmd_col,
    input  logic [$clog2(Nchars)-1:0]    cmd_char,
    input  logic                         vsync,
    output logic                         wr_en,
    output logic [$clog2(smem_size)-1:0] wr_addr,
    output logic [$clog2(Nchars)-1:0]    wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int ADDR_W = $clog2(smem_size);
    localparam int DATA_W = $clog2(Nchars);

    localparam logic [31:0]       NROWS_U   = 32'(nrows);
    localparam logic [31:0]       NCOLS_U   = 32'(ncols);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(smem_size - 1);

    // ------------------------------------------------------------------
    // vsync synchronizer; resets to the inactive (high) level so the gate
    // stays closed until the display actually reports blanking.
    // ------------------------------------------------------------------
    logic vsync_meta_q, vsync_s_q;
    logic gate;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_meta_q <= 1'b1;
            vsync_s_q    <= 1'b1;
        end else begin
            vsync_meta_q <= vsync;
            vsync_s_q    <= vsync_meta_q;
        end
    end

    assign gate = (SYNC_TO_VBLANK != 0) ? !vsync_s_q : 1'b1;

    // ------------------------------------------------------------------
    // Command FIFO. Its registered read port doubles as the current
    // command register: it only changes on a pop, and pops happen in IDLE.
    // ------------------------------------------------------------------
    cmd_t             cmd_in, cur_cmd;
    logic [CMD_W-1:0] cmd_in_bits, cur_cmd_bits;
    logic             fifo_full, fifo_empty, fifo_pop;

    always_comb begin
        cmd_in     = '0;
        cmd_in.op  = op_t'(cmd_op);
        cmd_in.row = ROW_W'(cmd_row);
        cmd_in.col = COL_W'(cmd_col);
        cmd_in.chr = CHAR_W'(cmd_char);
    end

    assign cmd_in_bits = cmd_in;
    assign cur_cmd     = cmd_t'(cur_cmd_bits);

    smem_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid),
        .push_data (cmd_in_bits),
        .pop       (fifo_pop),
        .pop_data  (cur_cmd_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Address decode: row*ncols+col evaluated at full 32-bit width, so the
    // range check sees the true row/col and the product never wraps before
    // it is narrowed to the RAM address width.
    // ------------------------------------------------------------------
    logic        in_range;
    logic [31:0] lin_addr;

    assign in_range = (32'(cur_cmd.row) < NROWS_U) && (32'(cur_cmd.col) < NCOLS_U);
    assign lin_addr = 32'(cur_cmd.row) * NCOLS_U + 32'(cur_cmd.col);

    // ------------------------------------------------------------------
    // Writer FSM. addr_q is the target cell for WRITE and the next cell to
    // be written for FILL. wr_en/wr_addr/wr_data are registered; the WRITE
    // state is the cycle in which wr_en is high for a command's final write,
    // and done follows it.
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fifo_pop  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                unique case (cur_cmd.op)
                    OP_WRITE: begin
                        if (in_range) begin
                            addr_d = lin_addr[ADDR_W-1:0];
                            // Open gate: issue straight away to keep the
                            // push-to-write latency at three cycles.
                            if (gate) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = lin_addr[ADDR_W-1:0];
                                wr_data_d = DATA_W'(cur_cmd.chr);
                                state_d   = ST_WRITE;
                            end else begin
                                state_d = ST_WAIT_GATE;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    OP_FILL: begin
                        addr_d  = '0;
                        state_d = ST_WAIT_GATE;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_WAIT_GATE: begin
                if (gate) begin
                    if (cur_cmd.op == OP_FILL) begin
                        state_d = ST_FILL;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = DATA_W'(cur_cmd.chr);
                        state_d   = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            ST_FILL: begin
                // A closed gate simply stalls here with addr_q held, so the
                // fill resumes at the same cell when blanking returns.
                if (gate) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = DATA_W'(cur_cmd.chr);
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_WRITE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_smem_writer.sv
`timescale 1ns/1ps
module tb_smem_writer;
    import smem_pkg::*;

    localparam int ADDR_W = $clog2(SMEM_SIZE);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // vblank-gated instance
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [ROW_W-1:0]  cmd_row;
    logic [COL_W-1:0]  cmd_col;
    logic [CHAR_W-1:0] cmd_char;
    logic              vsync, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_data;

    // ungated instance
    logic              n_cmd_valid, n_cmd_ready;
    logic [1:0]        n_cmd_op;
    logic [ROW_W-1:0]  n_cmd_row;
    logic [COL_W-1:0]  n_cmd_col;
    logic [CHAR_W-1:0] n_cmd_char;
    logic              n_vsync, n_wr_en, n_busy, n_done, n_err;
    logic [ADDR_W-1:0] n_wr_addr;
    logic [CHAR_W-1:0] n_wr_data;

    smem_writer #(.SYNC_TO_VBLANK(1)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_char(cmd_char),
        .vsync(vsync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    smem_writer #(.SYNC_TO_VBLANK(0)) dut_ng (
        .clk(clk), .reset_n(reset_n), .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
        .cmd_op(n_cmd_op), .cmd_row(n_cmd_row), .cmd_col(n_cmd_col), .cmd_char(n_cmd_char),
        .vsync(n_vsync), .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
        .busy(n_busy), .done(n_done), .err(n_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Write/done/err monitor for the gated instance (sampled on the falling edge).
    int q_addr[$];
    int q_data[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int n_wr_cnt = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            q_addr.push_back(int'(wr_addr));
            q_data.push_back(int'(wr_data));
        end
        if (done)    done_cnt++;
        if (err)     err_cnt++;
        if (n_wr_en) n_wr_cnt++;
    end

    task automatic push_cmd(input logic [1:0] op, input int row, input int col, input int ch);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = ROW_W'(row);
        cmd_col   = COL_W'(col);
        cmd_char  = CHAR_W'(ch);
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_val("push_timeout", guard, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("push op=%0d row=%0d col=%0d char=%0d", op, row, col, ch);
    endtask

    task automatic n_push_cmd(input logic [1:0] op, input int row, input int col, input int ch);
        n_cmd_valid = 1'b1;
        n_cmd_op    = op;
        n_cmd_row   = ROW_W'(row);
        n_cmd_col   = COL_W'(col);
        n_cmd_char  = CHAR_W'(ch);
        @(negedge clk);
        check_val("n_push_ready", int'(n_cmd_ready), 1);
        @(posedge clk);
        #1;
        n_cmd_valid = 1'b0;
        $display("push(ungated) op=%0d row=%0d col=%0d char=%0d", op, row, col, ch);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int guard;
        guard = 0;
        while (done_cnt < target && guard < budget) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= budget) check_val(tag, done_cnt, target);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Drops: row out of range, col out of range, reserved op.
    logic [1:0] bad_op  [3] = '{2'b00, 2'b00, 2'b10};
    int         bad_row [3] = '{30, 0, 1};
    int         bad_col [3] = '{0, 40, 1};

    logic stop_toggle;

    initial begin
        int base_done, base_err, base_nwr, bad, ready_seen, guard;
        int hits [SMEM_SIZE];

        cmd_valid = 0; cmd_op = '0; cmd_row = '0; cmd_col = '0; cmd_char = '0;
        n_cmd_valid = 0; n_cmd_op = '0; n_cmd_row = '0; n_cmd_col = '0; n_cmd_char = '0;
        vsync = 1'b1; n_vsync = 1'b1; stop_toggle = 1'b0;
        reset_n = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_val("rst_wr_en", int'(wr_en), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_cmd_ready", int'(cmd_ready), 1);
        check_val("rst_done_err", int'(done | err), 0);
        @(posedge clk); #1; reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // ---------------- 1: reset with queued commands ----------------
        for (int i = 0; i < 4; i++) push_cmd(2'b00, 0, i, 1);
        @(negedge clk);
        check_val("t1_busy_before", int'(busy), 1);
        q_addr.delete(); q_data.delete();
        base_done = done_cnt;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_val("t1_rst_wr_en", int'(wr_en), 0);
        check_val("t1_rst_busy", int'(busy), 0);
        check_val("t1_rst_ready", int'(cmd_ready), 1);
        @(posedge clk); #1; reset_n = 1'b1;
        vsync = 1'b0;
        repeat (40) @(posedge clk);
        check_val("t1_writes_after_rst", q_addr.size(), 0);
        check_val("t1_done_after_rst", done_cnt - base_done, 0);
        check_val("t1_busy_after", int'(busy), 0);
        #1 vsync = 1'b1;
        repeat (5) @(posedge clk); #1;

        // ---------------- 2: ungated single WRITE ----------------
        n_push_cmd(2'b00, 2, 5, 3);
        @(negedge clk); check_val("t2_n1_wr_en", int'(n_wr_en), 0);
        @(negedge clk); check_val("t2_n2_wr_en", int'(n_wr_en), 0);
        @(negedge clk);
        check_val("t2_n3_wr_en", int'(n_wr_en), 1);
        check_val("t2_n3_addr", int'(n_wr_addr), 85);
        check_val("t2_n3_data", int'(n_wr_data), 3);
        @(negedge clk);
        check_val("t2_n4_wr_en", int'(n_wr_en), 0);
        check_val("t2_n4_done", int'(n_done), 1);
        check_val("t2_n4_addr_hold", int'(n_wr_addr), 85);
        @(negedge clk);
        check_val("t2_n5_done", int'(n_done), 0);
        @(posedge clk); #1;

        // ---------------- 3: dropped commands ----------------
        for (int k = 0; k < 3; k++) begin
            base_nwr = n_wr_cnt;
            n_push_cmd(bad_op[k], bad_row[k], bad_col[k], 1);
            @(negedge clk); check_val("t3_n1_err", int'(n_err), 0);
            @(negedge clk); check_val("t3_n2_err", int'(n_err), 0);
            @(negedge clk); check_val("t3_n3_err", int'(n_err), 1);
            @(negedge clk);
            check_val("t3_n4_err", int'(n_err), 0);
            check_val("t3_n4_busy", int'(n_busy), 0);
            check_val("t3_no_write", n_wr_cnt - base_nwr, 0);
            @(posedge clk); #1;
        end

        // ---------------- 4: FILL with a paused gate ----------------
        q_addr.delete(); q_data.delete();
        base_done = done_cnt;
        push_cmd(2'b01, 0, 0, 1);
        repeat (5) @(posedge clk);
        #1 vsync = 1'b0;
        // The write of 496 is followed by three more before the closed gate
        // reaches the FSM through the synchronizer, so 499 is the last one.
        guard = 0;
        while (!(q_addr.size() > 0 && q_addr[$] == 496) && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 2000) check_val("t4_reach_496", q_addr.size(), 497);
        #1 vsync = 1'b1;
        repeat (100) @(posedge clk);
        check_val("t4_pause_count", q_addr.size(), 500);
        if (q_addr.size() > 0) check_val("t4_pause_last", q_addr[$], 499);
        check_val("t4_pause_busy", int'(busy), 1);
        #1 vsync = 1'b0;
        wait_done(base_done + 1, 3000, "t4_done_timeout");
        repeat (5) @(posedge clk);
        check_val("t4_total", q_addr.size(), SMEM_SIZE);
        check_val("t4_done_cnt", done_cnt - base_done, 1);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] != i || q_data[i] != 1) bad++;
        check_val("t4_seq_errors", bad, 0);
        if (q_addr.size() > 500) check_val("t4_resume_addr", q_addr[500], 500);
        check_val("t4_busy_end", int'(busy), 0);
        #1 vsync = 1'b1;
        repeat (5) @(posedge clk); #1;

        // ---------------- 5: full FIFO backpressure ----------------
        // One command is popped into the FSM right away, so five are
        // accepted (one waiting for the gate plus four in the FIFO).
        q_addr.delete(); q_data.delete();
        base_done = done_cnt;
        for (int i = 0; i < 5; i++) push_cmd(2'b00, 1, i, i % 4);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_row = ROW_W'(1); cmd_col = COL_W'(5); cmd_char = CHAR_W'(1);
        @(negedge clk);
        check_val("t5_ready_full", int'(cmd_ready), 0);
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready) ready_seen++;
        end
        check_val("t5_ready_stays_low", ready_seen, 0);
        check_val("t5_no_write_closed", q_addr.size(), 0);
        vsync = 1'b0;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_val("t5_accept_timeout", guard, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        $display("push op=0 row=1 col=5 char=1 (held while full)");
        wait_done(base_done + 6, 400, "t5_done_timeout");
        repeat (3) @(posedge clk);
        check_val("t5_write_count", q_addr.size(), 6);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] != 40 + i || q_data[i] != i % 4) bad++;
        check_val("t5_order_errors", bad, 0);
        #1 vsync = 1'b1;
        repeat (5) @(posedge clk); #1;

        // ---------------- 6: FILL under random vsync ----------------
        q_addr.delete(); q_data.delete();
        base_done = done_cnt;
        base_err  = err_cnt;
        push_cmd(2'b01, 0, 0, 2);
        fork
            begin
                while (!stop_toggle) begin
                    vsync = 1'b0;
                    #($urandom_range(5000, 50000) * 0.01);
                    vsync = 1'b1;
                    #($urandom_range(2000, 20000) * 0.01);
                end
            end
        join_none
        wait_done(base_done + 1, 30000, "t6_done_timeout");
        stop_toggle = 1'b1;
        repeat (5) @(posedge clk);
        foreach (hits[i]) hits[i] = 0;
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] >= 0 && q_addr[i] < SMEM_SIZE) hits[q_addr[i]]++;
            if (q_data[i] != 2) bad++;
        end
        for (int i = 0; i < SMEM_SIZE; i++)
            if (hits[i] != 1) bad++;
        check_val("t6_total", q_addr.size(), SMEM_SIZE);
        check_val("t6_coverage_errors", bad, 0);
        check_val("t6_done_cnt", done_cnt - base_done, 1);
        check_val("t6_no_err", err_cnt - base_err, 0);
        if (q_addr.size() > 0) check_val("t6_last_addr", q_addr[$], SMEM_SIZE - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
